id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage for the 5-stage RV32I core. It captures the register-file read data, immediate, PC values and decoded control from the decode stage into the EX-stage pipeline register. It detects load-use hazards and stalls IF/ID by injecting a bubble, and applies branch/jump flushes from EX. It also produces the EX operand forwarding selects and two saturating hazard performance counters.

## Interface

Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of each performance counter

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge
- RST  in  1  synchronous reset, active-high
- ID_Valid  in  1  decode slot holds a real instruction
- ID_Rs1, ID_Rs2, ID_Rd  in  5 each  register indices
- ID_RD1, ID_RD2  in  XLEN each  register-file read data
- ID_ImmExt, ID_PC, ID_PCPlus4  in  XLEN each
- ID_RegWrite, ID_MemWrite, ID_Branch, ID_Jump, ID_ALUSrc  in  1 each
- ID_ResultSrc  in  2  00 ALU, 01 load, 10 PC+4
- ID_ALUControl  in  3
- EX_Flush  in  1  taken branch/jump resolved in EX
- MEM_Rd, WB_Rd  in  5 each; MEM_RegWrite, WB_RegWrite  in  1 each
- EX_* outputs  out  same widths as the ID_* inputs above, plus EX_Valid; registered
- Stall_F, Stall_D  out  1 each  hold PC and IF/ID register
- ForwardA, ForwardB  out  2 each  00 register data, 10 MEM ALU result, 01 WB result
- Bubble_Count, Flush_Count  out  CNT_W each

## Operation

- Load-use hazard: Hz = EX_Valid & EX_RegWrite & (EX_ResultSrc==01) & (EX_Rd!=0) & ID_Valid & (EX_Rd==ID_Rs1 | EX_Rd==ID_Rs2).
- Stall_F = Stall_D = Hz & ~EX_Flush. Combinational.
- Register update priority at each rising edge, in order:
  1. RST: all EX_* registers to 0, counters to 0.
  2. EX_Flush: bubble loaded, Flush_Count incremented.
  3. Hz: bubble loaded, Bubble_Count incremented.
  4. Otherwise: all ID_* inputs are captured.
- Bubble: every EX_* register is 0, so EX_Valid, EX_RegWrite, EX_MemWrite, EX_Branch and EX_Jump are all 0.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Forwarding is combinational from the EX register contents:
  - ForwardA = 10 if MEM_RegWrite & MEM_Rd!=0 & MEM_Rd==EX_Rs1.
  - Otherwise ForwardA = 01 if WB_RegWrite & WB_Rd!=0 & WB_Rd==EX_Rs1.
  - Otherwise ForwardA = 00.
  - ForwardB uses the same rule on EX_Rs2.
  - MEM has priority over WB.
  - When EX_Valid=0, both forwarding selects are 00.
- No WB-to-ID bypass. The register file commits on the falling edge, so ID_RD1/ID_RD2 already reflect the WB write of the same cycle.
- Index x0 never matches for forwarding or hazard detection.

## Timing

- Latency is 1 cycle, ID inputs to EX outputs.
- Stall_F/Stall_D and ForwardA/ForwardB are same-cycle combinational.
- Reset values: all EX_* outputs 0, Stall_F/Stall_D 0, ForwardA/ForwardB 00, both counters 0.
- A load-use hazard costs exactly one bubble cycle. In the following cycle the load sits in MEM, Hz deasserts, and ForwardA/B=10 must not be chosen for load data. Instead the consumer is captured one cycle later and receives the value via WB forwarding (01).
- EX_Flush and Hz in the same cycle: one bubble, Flush_Count increments, Bubble_Count does not, and Stall_D stays 0.
- RST asserted mid-stream: takes effect at the next edge regardless of EX_Flush or Hz. The pipeline is empty on the following cycle.

## Test plan

- Reset: hold RST for 2 cycles with nonzero ID_* inputs -> all EX_* outputs 0, counters 0, ForwardA/B 00.
- Pass-through: ID_Valid=1, ID_RD1=0x12345678, ID_Rd=5, ID_RegWrite=1 -> next cycle EX_RD1=0x12345678, EX_Rd=5, EX_Valid=1, and Stall_D stays 0.
- Load-use: lw x3 in EX, then add x4,x3,x1 in ID -> Stall_D=1 for exactly 1 cycle, one bubble in EX, Bubble_Count=1. When the add reaches EX, ForwardA=01 with WB_Rd=3.
- Forwarding priority: EX_Rs1=7, MEM_Rd=7, WB_Rd=7, both RegWrite=1 -> ForwardA=10. Change MEM_Rd to 0 -> ForwardA=01. Change all indices to 0 -> ForwardA=00.
- Flush vs. stall: assert EX_Flush in the same cycle as the load-use condition -> Stall_D=0, next EX_Valid=0, Flush_Count+1, Bubble_Count unchanged.
- Saturation: with CNT_W=4, apply 20 flushes -> Flush_Count stays at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core: load-use stall/bubble,
// EX flush handling, EX operand forwarding selects and saturating hazard counters.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ID_Valid,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic [4:0]       ID_Rd,
    input  logic [XLEN-1:0]  ID_RD1,
    input  logic [XLEN-1:0]  ID_RD2,
    input  logic [XLEN-1:0]  ID_ImmExt,
    input  logic [XLEN-1:0]  ID_PC,
    input  logic [XLEN-1:0]  ID_PCPlus4,
    input  logic             ID_RegWrite,
    input  logic             ID_MemWrite,
    input  logic             ID_Branch,
    input  logic             ID_Jump,
    input  logic             ID_ALUSrc,
    input  logic [1:0]       ID_ResultSrc,
    input  logic [2:0]       ID_ALUControl,
    input  logic             EX_Flush,
    input  logic [4:0]       MEM_Rd,
    input  logic [4:0]       WB_Rd,
    input  logic             MEM_RegWrite,
    input  logic             WB_RegWrite,
    output logic             EX_Valid,
    output logic [4:0]       EX_Rs1,
    output logic [4:0]       EX_Rs2,
    output logic [4:0]       EX_Rd,
    output logic [XLEN-1:0]  EX_RD1,
    output logic [XLEN-1:0]  EX_RD2,
    output logic [XLEN-1:0]  EX_ImmExt,
    output logic [XLEN-1:0]  EX_PC,
    output logic [XLEN-1:0]  EX_PCPlus4,
    output logic             EX_RegWrite,
    output logic             EX_MemWrite,
    output logic             EX_Branch,
    output logic             EX_Jump,
    output logic             EX_ALUSrc,
    output logic [1:0]       EX_ResultSrc,
    output logic [2:0]       EX_ALUControl,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] Bubble_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    logic hz;
    logic load_bubble;

    assign hz = EX_Valid && EX_RegWrite && (EX_ResultSrc == 2'b01) && (EX_Rd != '0)
                && ID_Valid && ((EX_Rd == ID_Rs1) || (EX_Rd == ID_Rs2));

    // A flush discards the stalled consumer anyway, so it overrides the stall.
    assign Stall_F     = hz && !EX_Flush;
    assign Stall_D     = hz && !EX_Flush;
    assign load_bubble = RST || EX_Flush || hz;

    always_ff @(posedge CLK) begin
        if (load_bubble) begin
            EX_Valid      <= 1'b0;
            EX_Rs1        <= '0;
            EX_Rs2        <= '0;
            EX_Rd         <= '0;
            EX_RD1        <= '0;
            EX_RD2        <= '0;
            EX_ImmExt     <= '0;
            EX_PC         <= '0;
            EX_PCPlus4    <= '0;
            EX_RegWrite   <= 1'b0;
            EX_MemWrite   <= 1'b0;
            EX_Branch     <= 1'b0;
            EX_Jump       <= 1'b0;
            EX_ALUSrc     <= 1'b0;
            EX_ResultSrc  <= '0;
            EX_ALUControl <= '0;
        end else begin
            EX_Valid      <= ID_Valid;
            EX_Rs1        <= ID_Rs1;
            EX_Rs2        <= ID_Rs2;
            EX_Rd         <= ID_Rd;
            EX_RD1        <= ID_RD1;
            EX_RD2        <= ID_RD2;
            EX_ImmExt     <= ID_ImmExt;
            EX_PC         <= ID_PC;
            EX_PCPlus4    <= ID_PCPlus4;
            EX_RegWrite   <= ID_RegWrite;
            EX_MemWrite   <= ID_MemWrite;
            EX_Branch     <= ID_Branch;
            EX_Jump       <= ID_Jump;
            EX_ALUSrc     <= ID_ALUSrc;
            EX_ResultSrc  <= ID_ResultSrc;
            EX_ALUControl <= ID_ALUControl;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Bubble_Count <= '0;
            Flush_Count  <= '0;
        end else if (EX_Flush) begin
            if (Flush_Count != '1)
                Flush_Count <= Flush_Count + CNT_W'(1);
        end else if (hz) begin
            if (Bubble_Count != '1)
                Bubble_Count <= Bubble_Count + CNT_W'(1);
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (MEM_RegWrite && (MEM_Rd != '0) && (MEM_Rd == rs))
            sel = 2'b10;
        else if (WB_RegWrite && (WB_Rd != '0) && (WB_Rd == rs))
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (EX_Valid) begin
            ForwardA = fwd_sel(EX_Rs1);
            ForwardB = fwd_sel(EX_Rs2);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a cycle-level model predicts the EX register,
// counters, stalls and forwarding selects; monitors compare what the DUT presents.
module tb_id_ex_stage;

    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = 15;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic        regwrite, memwrite, branch, jump, alusrc;
        logic [1:0]  resultsrc;
        logic [2:0]  aluctl;
    } instr_t;

    typedef struct packed {
        instr_t     id;
        logic       rst, flush;
        logic [4:0] mem_rd, wb_rd;
        logic       mem_rw, wb_rw;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] fa, fb;
    } comb_exp_t;

    typedef struct packed {
        instr_t ex;
        int     bc, fc;
    } seq_exp_t;

    logic CLK = 1'b0;
    logic RST, ID_Valid, ID_RegWrite, ID_MemWrite, ID_Branch, ID_Jump, ID_ALUSrc;
    logic [4:0] ID_Rs1, ID_Rs2, ID_Rd, MEM_Rd, WB_Rd;
    logic [31:0] ID_RD1, ID_RD2, ID_ImmExt, ID_PC, ID_PCPlus4;
    logic [1:0] ID_ResultSrc;
    logic [2:0] ID_ALUControl;
    logic EX_Flush, MEM_RegWrite, WB_RegWrite;
    logic EX_Valid, EX_RegWrite, EX_MemWrite, EX_Branch, EX_Jump, EX_ALUSrc;
    logic [4:0] EX_Rs1, EX_Rs2, EX_Rd;
    logic [31:0] EX_RD1, EX_RD2, EX_ImmExt, EX_PC, EX_PCPlus4;
    logic [1:0] EX_ResultSrc, ForwardA, ForwardB;
    logic [2:0] EX_ALUControl;
    logic Stall_F, Stall_D;
    logic [CNT_W-1:0] Bubble_Count, Flush_Count;

    id_ex_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ID_Valid(ID_Valid),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Rd(ID_Rd),
        .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_ImmExt(ID_ImmExt),
        .ID_PC(ID_PC), .ID_PCPlus4(ID_PCPlus4),
        .ID_RegWrite(ID_RegWrite), .ID_MemWrite(ID_MemWrite), .ID_Branch(ID_Branch),
        .ID_Jump(ID_Jump), .ID_ALUSrc(ID_ALUSrc), .ID_ResultSrc(ID_ResultSrc),
        .ID_ALUControl(ID_ALUControl), .EX_Flush(EX_Flush),
        .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd), .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
        .EX_Valid(EX_Valid), .EX_Rs1(EX_Rs1), .EX_Rs2(EX_Rs2), .EX_Rd(EX_Rd),
        .EX_RD1(EX_RD1), .EX_RD2(EX_RD2), .EX_ImmExt(EX_ImmExt),
        .EX_PC(EX_PC), .EX_PCPlus4(EX_PCPlus4),
        .EX_RegWrite(EX_RegWrite), .EX_MemWrite(EX_MemWrite), .EX_Branch(EX_Branch),
        .EX_Jump(EX_Jump), .EX_ALUSrc(EX_ALUSrc), .EX_ResultSrc(EX_ResultSrc),
        .EX_ALUControl(EX_ALUControl), .Stall_F(Stall_F), .Stall_D(Stall_D),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .Bubble_Count(Bubble_Count), .Flush_Count(Flush_Count)
    );

    always #5 CLK = ~CLK;

    instr_t ex_dut;
    assign ex_dut = {EX_Valid, EX_Rs1, EX_Rs2, EX_Rd, EX_RD1, EX_RD2, EX_ImmExt, EX_PC,
                     EX_PCPlus4, EX_RegWrite, EX_MemWrite, EX_Branch, EX_Jump, EX_ALUSrc,
                     EX_ResultSrc, EX_ALUControl};

    int tests = 0;
    int fails = 0;
    comb_exp_t comb_q[$];
    seq_exp_t  seq_q[$];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        comb_exp_t c;
        if (comb_q.size() > 0) begin
            c = comb_q.pop_front();
            check("Stall_F", 192'(Stall_F), 192'(c.stall));
            check("Stall_D", 192'(Stall_D), 192'(c.stall));
            check("ForwardA", 192'(ForwardA), 192'(c.fa));
            check("ForwardB", 192'(ForwardB), 192'(c.fb));
        end
    end

    always @(posedge CLK) begin
        seq_exp_t s;
        #1;
        if (seq_q.size() > 0) begin
            s = seq_q.pop_front();
            check("EX_regs", 192'(ex_dut), 192'(s.ex));
            check("Bubble_Count", 192'(Bubble_Count), 192'(s.bc));
            check("Flush_Count", 192'(Flush_Count), 192'(s.fc));
        end
    end

    // Reference model state: what the EX register and counters should hold now.
    instr_t m_ex;
    int     m_bc, m_fc;
    bit     m_known = 0;

    function automatic logic model_hz(input instr_t ex, input stim_t s);
        return ex.valid && ex.regwrite && ex.resultsrc == 2'b01 && ex.rd != 0 && s.id.valid
               && (ex.rd == s.id.rs1 || ex.rd == s.id.rs2);
    endfunction

    function automatic logic [1:0] model_fwd(input instr_t ex, input logic [4:0] rs, input stim_t s);
        if (!ex.valid) return 2'b00;
        if (s.mem_rw && s.mem_rd != 0 && s.mem_rd == rs) return 2'b10;
        if (s.wb_rw && s.wb_rd != 0 && s.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic apply(input stim_t s);
        logic hz;
        @(posedge CLK);
        #2;
        RST = s.rst; EX_Flush = s.flush;
        ID_Valid = s.id.valid; ID_Rs1 = s.id.rs1; ID_Rs2 = s.id.rs2; ID_Rd = s.id.rd;
        ID_RD1 = s.id.rd1; ID_RD2 = s.id.rd2; ID_ImmExt = s.id.imm;
        ID_PC = s.id.pc; ID_PCPlus4 = s.id.pc4;
        ID_RegWrite = s.id.regwrite; ID_MemWrite = s.id.memwrite; ID_Branch = s.id.branch;
        ID_Jump = s.id.jump; ID_ALUSrc = s.id.alusrc; ID_ResultSrc = s.id.resultsrc;
        ID_ALUControl = s.id.aluctl;
        MEM_Rd = s.mem_rd; WB_Rd = s.wb_rd; MEM_RegWrite = s.mem_rw; WB_RegWrite = s.wb_rw;
        hz = model_hz(m_ex, s);
        if (m_known)
            comb_q.push_back('{stall: hz && !s.flush, fa: model_fwd(m_ex, m_ex.rs1, s),
                               fb: model_fwd(m_ex, m_ex.rs2, s)});
        if (s.rst) begin
            m_ex = '0; m_bc = 0; m_fc = 0; m_known = 1;
        end else if (s.flush) begin
            m_ex = '0; m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        end else if (hz) begin
            m_ex = '0; m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
        end else begin
            m_ex = s.id;
        end
        if (m_known) seq_q.push_back('{ex: m_ex, bc: m_bc, fc: m_fc});
    endtask

    function automatic logic [4:0] rand_idx();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.id.valid = ($urandom_range(0, 4) != 0);
        s.id.rs1 = rand_idx(); s.id.rs2 = rand_idx(); s.id.rd = rand_idx();
        s.id.rd1 = $urandom; s.id.rd2 = $urandom; s.id.imm = $urandom;
        s.id.pc = $urandom; s.id.pc4 = s.id.pc + 4;
        s.id.regwrite = 1'($urandom); s.id.memwrite = 1'($urandom); s.id.branch = 1'($urandom);
        s.id.jump = 1'($urandom); s.id.alusrc = 1'($urandom);
        s.id.resultsrc = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom);
        s.id.aluctl = 3'($urandom);
        s.rst = 1'b0; s.flush = 1'b0;
        s.mem_rd = rand_idx(); s.wb_rd = rand_idx();
        s.mem_rw = 1'($urandom); s.wb_rw = 1'($urandom);
        return s;
    endfunction

    function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [1:0] rsrc);
        stim_t s;
        s = rand_stim();
        s.id.valid = 1'b1; s.id.rs1 = rs1; s.id.rs2 = rs2; s.id.rd = rd;
        s.id.regwrite = 1'b1; s.id.resultsrc = rsrc;
        s.mem_rw = 1'b0; s.wb_rw = 1'b0; s.mem_rd = 0; s.wb_rd = 0;
        return s;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        // reset with busy ID inputs
        for (int i = 0; i < 2; i++) begin
            s = rand_stim(); s.id.valid = 1'b1; s.rst = 1'b1; apply(s);
        end
        // pass-through
        s = mk(5'd1, 5'd2, 5'd5, 2'b00); s.id.rd1 = 32'h12345678; apply(s);
        // load-use: lw x3, then add x4,x3,x1 stalls once, then forwards from WB
        apply(mk(5'd2, 5'd0, 5'd3, 2'b01));
        apply(mk(5'd3, 5'd1, 5'd4, 2'b00));
        s = mk(5'd3, 5'd1, 5'd4, 2'b00); s.mem_rd = 3; s.mem_rw = 1; apply(s);
        s = mk(5'd9, 5'd10, 5'd11, 2'b00); s.wb_rd = 3; s.wb_rw = 1; apply(s);
        // forwarding priority on EX_Rs1=7
        apply(mk(5'd7, 5'd7, 5'd8, 2'b00));
        s = mk(5'd7, 5'd7, 5'd8, 2'b00); s.mem_rd = 7; s.wb_rd = 7; s.mem_rw = 1; s.wb_rw = 1; apply(s);
        s.mem_rd = 0; apply(s);
        s.wb_rd = 0; s.id.rs1 = 0; s.id.rs2 = 0; apply(s);
        // flush coinciding with a load-use hazard
        apply(mk(5'd0, 5'd0, 5'd6, 2'b01));
        s = mk(5'd6, 5'd6, 5'd2, 2'b00); s.flush = 1'b1; apply(s);
        // counter saturation
        for (int i = 0; i < 20; i++) begin
            s = rand_stim(); s.flush = 1'b1; apply(s);
        end
        // reset mid-stream while flush and hazard are pending
        apply(mk(5'd0, 5'd0, 5'd2, 2'b01));
        s = mk(5'd2, 5'd0, 5'd1, 2'b00); s.rst = 1'b1; s.flush = 1'b1; apply(s);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            s = rand_stim();
            s.flush = ($urandom_range(0, 5) == 0);
            s.rst = ($urandom_range(0, 60) == 0);
            apply(s);
        end
        repeat (3) @(posedge CLK);
        #2;
        check("scoreboard_drain", 192'(comb_q.size() + seq_q.size()), 192'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
